sgd_predict: RTL and testbench

Inference stage that sits directly downstream of the SGD training engine. It takes the packed weight vector the trainer drives onto its data bus on completion and walks the same data-point RAM by address. For each point it computes y_hat = w0 + Σ wk·xk with three fixed-point multipliers per cycle, then streams y_hat, the residual (y − y_hat) and the point address out over a valid/ready handshake.

---
 rtl/sgd_pkg.sv | 43 ++++
 rtl/sgd_fx_mul.sv | 15 +
 rtl/sgd_predict.sv | 159 +++++++++++++++
 tb/tb_sgd_predict.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgd_pkg.sv
// Shared widths, FSM encoding and fixed-point helpers for the SGD inference stage.
package sgd_pkg;

    localparam int LENGTH       = 16;
    localparam int MAX_FEATURES = 15;
    localparam int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1);
    localparam int FRAC         = 8;
    localparam int MAX_MUL      = 3;
    localparam int PROD_W       = 2 * LENGTH - FRAC;
    localparam int ACC_W        = PROD_W + 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_MAC   = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Slice 0 sits in the most significant field of the packed vector.
    function automatic logic [LENGTH-1:0] get_slice(input logic [DATA_WIDTH-1:0] v,
                                                    input logic [3:0]            k);
        return LENGTH'(v >> (LENGTH * (MAX_FEATURES - int'(k))));
    endfunction

    function automatic logic [LENGTH-1:0] sat_acc(input logic [ACC_W-1:0] a);
        if (a[ACC_W-1:LENGTH-1] == '0 || a[ACC_W-1:LENGTH-1] == '1)
            return a[LENGTH-1:0];
        else if (a[ACC_W-1])
            return {1'b1, {(LENGTH-1){1'b0}}};
        return {1'b0, {(LENGTH-1){1'b1}}};
    endfunction

    function automatic logic [LENGTH-1:0] sat_err(input logic [LENGTH:0] d);
        if (d[LENGTH] == d[LENGTH-1])
            return d[LENGTH-1:0];
        else if (d[LENGTH])
            return {1'b1, {(LENGTH-1){1'b0}}};
        return {1'b0, {(LENGTH-1){1'b1}}};
    endfunction

endpackage

// File: rtl/sgd_fx_mul.sv
// Signed fixed-point multiply; the product is shifted down by FRAC and kept at full width.
module sgd_fx_mul
    import sgd_pkg::*;
(
    input  logic signed [LENGTH-1:0] a,
    input  logic signed [LENGTH-1:0] b,
    output logic signed [PROD_W-1:0] p
);

    logic signed [2*LENGTH-1:0] full;

    assign full = a * b;
    assign p    = PROD_W'(full >>> FRAC);

endmodule

// File: rtl/sgd_predict.sv
// Inference pass over the data-point RAM: y_hat = w0 + sum(wk*xk), streamed with residual.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start after reset
// FETCH   | addr presented to the RAM
// LATCH   | RAM data captured, accumulator seeded with w0
// MAC     | three features multiplied and accumulated per cycle
// OUT     | result offered on y_valid until y_ready
// DONE    | pass complete, waiting for start
module sgd_predict
    import sgd_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] weights,
    input  logic [3:0]            feat,
    input  logic [ADDR_WIDTH-1:0] data_points,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LENGTH-1:0]     y_hat,
    output logic [LENGTH-1:0]     err,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  busy,
    output logic                  done
);

    state_t state, state_nx;

    logic [DATA_WIDTH-1:0]   w_reg;
    logic [DATA_WIDTH-1:0]   xbuf;
    logic [3:0]              feat_reg;
    logic [ADDR_WIDTH-1:0]   np_reg;
    logic [2:0]              pass;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_sum;
    logic [ACC_W-1:0]        acc_w0;
    logic [ACC_W-1:0]        acc_fin;
    logic [LENGTH-1:0]       w0;
    logic [LENGTH-1:0]       y_cur;
    logic [LENGTH-1:0]       y_hat_nx;
    logic [LENGTH:0]         diff;
    logic [4:0]              covered;
    logic                    last_pass;
    logic                    launch;
    logic                    xfer;
    logic                    enter_out;

    logic signed [LENGTH-1:0] x_op [MAX_MUL];
    logic signed [LENGTH-1:0] w_op [MAX_MUL];
    logic signed [PROD_W-1:0] prod [MAX_MUL];

    // Operand lanes: lane m of pass p handles feature 3p+m+1, zeroed beyond feat.
    for (genvar m = 0; m < MAX_MUL; m++) begin : g_mul
        logic [4:0] idx;
        logic       use_op;

        assign idx     = {2'b00, pass} * 5'd3 + 5'(m + 1);
        assign use_op  = (idx <= {1'b0, feat_reg});
        assign x_op[m] = use_op ? get_slice(xbuf,  idx[3:0]) : '0;
        assign w_op[m] = use_op ? get_slice(w_reg, idx[3:0]) : '0;

        sgd_fx_mul u_mul (
            .a (x_op[m]),
            .b (w_op[m]),
            .p (prod[m])
        );
    end

    always_comb begin
        acc_sum = acc;
        for (int m = 0; m < MAX_MUL; m++)
            acc_sum = acc_sum + {{(ACC_W-PROD_W){prod[m][PROD_W-1]}}, prod[m]};
    end

    assign w0        = get_slice(w_reg, 4'd0);
    assign acc_w0    = {{(ACC_W-LENGTH){w0[LENGTH-1]}}, w0};
    assign covered   = {2'b00, pass} * 5'd3 + 5'd3;
    assign last_pass = (covered >= {1'b0, feat_reg});
    assign launch    = start && (state == S_IDLE || state == S_DONE);
    assign xfer      = (state == S_OUT) && y_ready;
    assign enter_out = (state_nx == S_OUT) && (state != S_OUT);

    // With feat == 0 the result leaves LATCH directly, before xbuf holds y.
    assign acc_fin  = (state == S_LATCH) ? acc_w0 : acc_sum;
    assign y_cur    = (state == S_LATCH) ? get_slice(data, 4'd0) : get_slice(xbuf, 4'd0);
    assign y_hat_nx = sat_acc(acc_fin);
    assign diff     = {y_cur[LENGTH-1], y_cur} - {y_hat_nx[LENGTH-1], y_hat_nx};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = (data_points == '0) ? S_DONE : S_FETCH;
            S_FETCH:        state_nx = S_LATCH;
            S_LATCH:        state_nx = (feat_reg == 4'd0) ? S_OUT : S_MAC;
            S_MAC:          if (last_pass) state_nx = S_OUT;
            S_OUT:          if (y_ready) state_nx = (addr == np_reg) ? S_DONE : S_FETCH;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        y_valid = (state == S_OUT);
        busy    = (state != S_IDLE) && (state != S_DONE);
        done    = (state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            w_reg    <= '0;
            feat_reg <= '0;
            np_reg   <= '0;
            xbuf     <= '0;
            acc      <= '0;
            pass     <= '0;
            addr     <= '0;
            y_hat    <= '0;
            err      <= '0;
            y_addr   <= '0;
        end else begin
            if (launch) begin
                w_reg    <= weights;
                feat_reg <= feat;
                np_reg   <= data_points;
                if (data_points != '0)
                    addr <= ADDR_WIDTH'(1);
            end
            if (state == S_LATCH) begin
                xbuf <= data;
                acc  <= acc_w0;
                pass <= '0;
            end
            if (state == S_MAC) begin
                acc  <= acc_sum;
                pass <= pass + 3'd1;
            end
            if (enter_out) begin
                y_hat  <= y_hat_nx;
                err    <= sat_err(diff);
                y_addr <= addr;
            end
            if (xfer && addr != np_reg)
                addr <= addr + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_sgd_predict.sv
// Self-checking bench for sgd_predict: directed vectors, randomized passes, reset and restart cases.
module tb_sgd_predict;
    import sgd_pkg::*;

    localparam int DW = DATA_WIDTH;

    logic          CLK;
    logic          RST;
    logic          start;
    logic [DW-1:0] weights;
    logic [3:0]    feat;
    logic [11:0]   data_points;
    logic [DW-1:0] data;
    logic [11:0]   addr;
    logic [15:0]   y_hat;
    logic [15:0]   err;
    logic [11:0]   y_addr;
    logic          y_valid;
    logic          y_ready;
    logic          busy;
    logic          done;

    sgd_predict #(.ADDR_WIDTH(12)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .weights     (weights),
        .feat        (feat),
        .data_points (data_points),
        .data        (data),
        .addr        (addr),
        .y_hat       (y_hat),
        .err         (err),
        .y_addr      (y_addr),
        .y_valid     (y_valid),
        .y_ready     (y_ready),
        .busy        (busy),
        .done        (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous-read RAM: data follows addr by one clock.
    logic [DW-1:0] mem [0:15];
    always @(posedge CLK) data <= mem[addr[3:0]];

    int n_checks;
    int n_fail;

    logic [DW-1:0] wv_cur;
    logic [3:0]    feat_cur;
    logic [15:0]   exp_yh [0:15];
    logic [15:0]   exp_e  [0:15];

    typedef struct {
        logic [DW-1:0] wv;
        logic [DW-1:0] xv;
        logic [3:0]    f;
        logic [15:0]   yh;
        logic [15:0]   e;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] setf(input logic [DW-1:0] v, input int k, input logic [15:0] val);
        logic [DW-1:0] msk;
        logic [DW-1:0] fld;
        msk = {{(DW-16){1'b0}}, 16'hFFFF} << (DW - 16*(k+1));
        fld = {{(DW-16){1'b0}}, val} << (DW - 16*(k+1));
        return (v & ~msk) | fld;
    endfunction

    function automatic logic [DW-1:0] allf(input logic [15:0] val);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v = setf(v, k, val);
        return v;
    endfunction

    function automatic longint fldv(input logic [DW-1:0] v, input int k);
        logic [DW-1:0]      t;
        logic signed [15:0] f;
        t = v >> (DW - 16*(k+1));
        f = t[15:0];
        return longint'(f);
    endfunction

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference: bias plus floor-shifted products over the active features, then saturate.
    function automatic void model(input logic [DW-1:0] wv, input logic [DW-1:0] xv, input int f,
                                  output logic [15:0] yh, output logic [15:0] e);
        longint s;
        s = fldv(wv, 0);
        for (int k = 1; k <= f; k++) s += (fldv(xv, k) * fldv(wv, k)) >>> 8;
        s  = clamp16(s);
        yh = 16'(s);
        e  = 16'(clamp16(fldv(xv, 0) - s));
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v;
        logic [15:0]   f;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(0, 3) == 0) f = 16'($urandom);
            else                           f = 16'($urandom_range(0, 2047)) - 16'd1024;
            v = setf(v, k, f);
        end
        return v;
    endfunction

    task automatic run_pass(input int dp, input int stall, input bit poke, input string tag);
        int n_rx;
        int last_tx;
        int stall_cnt;
        int lat;
        bit in_out;
        bit seen_done;
        n_rx = 0; last_tx = 0; stall_cnt = 0; in_out = 0; seen_done = 0;
        lat = 3 + (int'(feat_cur) + 2) / 3;
        weights     = wv_cur;
        feat        = feat_cur;
        data_points = 12'(dp);
        start       = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(posedge CLK); #1;
            start = 1'b0;
            if (poke && cyc == 2) begin
                start       = 1'b1;
                weights     = ~wv_cur;
                feat        = ~feat_cur;
                data_points = 12'(dp + 1);
            end
            if (done) begin
                check({tag, " done_cycle"}, 64'(cyc), 64'((dp == 0) ? 1 : last_tx + 1));
                check({tag, " rx_count"}, 64'(n_rx), 64'(dp));
                check({tag, " busy_at_done"}, 64'(busy), 64'd0);
                seen_done = 1;
                break;
            end
            check({tag, " busy"}, 64'(busy), 64'd1);
            if (y_valid && n_rx < 15) begin
                if (!in_out) begin
                    in_out    = 1;
                    stall_cnt = stall;
                    check({tag, " valid_latency"}, 64'(cyc), 64'((n_rx == 0) ? lat : last_tx + lat));
                end
                check({tag, " y_addr"}, 64'(y_addr), 64'(n_rx + 1));
                check({tag, " addr"},   64'(addr),   64'(n_rx + 1));
                check({tag, " y_hat"},  64'(y_hat),  64'(exp_yh[n_rx+1]));
                check({tag, " err"},    64'(err),    64'(exp_e[n_rx+1]));
                y_ready = (stall_cnt == 0);
                if (stall_cnt > 0) stall_cnt--;
                if (y_ready) begin
                    n_rx++;
                    last_tx = cyc;
                    in_out  = 0;
                end
            end else begin
                if (n_rx > 0) begin
                    check({tag, " held_y_hat"},  64'(y_hat),  64'(exp_yh[n_rx]));
                    check({tag, " held_y_addr"}, 64'(y_addr), 64'(n_rx));
                end
                y_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!seen_done) check({tag, " timeout"}, 64'd0, 64'd1);
        weights = '0;
        feat    = '0;
    endtask

    initial begin
        int dp;
        n_checks = 0;
        n_fail   = 0;
        RST = 1'b0; start = 1'b0; weights = '0; feat = '0; data_points = '0; y_ready = 1'b0;
        for (int a = 0; a < 16; a++) begin
            mem[a] = '0; exp_yh[a] = '0; exp_e[a] = '0;
        end

        repeat (2) @(posedge CLK);
        #1;
        check("reset addr",    64'(addr),    64'd0);
        check("reset y_hat",   64'(y_hat),   64'd0);
        check("reset err",     64'(err),     64'd0);
        check("reset y_addr",  64'(y_addr),  64'd0);
        check("reset y_valid", 64'(y_valid), 64'd0);
        check("reset busy",    64'(busy),    64'd0);
        check("reset done",    64'(done),    64'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        tbl[0].wv = setf(setf('0, 0, 16'h0100), 1, 16'h0200);
        tbl[0].xv = setf(setf('0, 0, 16'h0700), 1, 16'h0300);
        tbl[0].f = 4'd1;  tbl[0].yh = 16'h0700; tbl[0].e = 16'h0000;
        tbl[1].wv = allf(16'h0100);
        tbl[1].xv = setf(allf(16'h0100), 0, 16'h0000);
        tbl[1].f = 4'd15; tbl[1].yh = 16'h1000; tbl[1].e = 16'hF000;
        tbl[2].wv = tbl[1].wv; tbl[2].xv = tbl[1].xv;
        tbl[2].f = 4'd4;  tbl[2].yh = 16'h0500; tbl[2].e = 16'hFB00;
        tbl[3].wv = setf(setf(setf('0, 1, 16'h7F00), 2, 16'h7F00), 3, 16'h7F00);
        tbl[3].xv = setf(setf(setf('0, 1, 16'h0200), 2, 16'h0200), 3, 16'h7F00);
        tbl[3].f = 4'd2;  tbl[3].yh = 16'h7FFF; tbl[3].e = 16'h8001;
        tbl[4].wv = setf('0, 1, 16'h8000);
        tbl[4].xv = setf(setf('0, 0, 16'h7000), 1, 16'h0200);
        tbl[4].f = 4'd1;  tbl[4].yh = 16'h8000; tbl[4].e = 16'h7FFF;
        tbl[5].wv = setf(setf('0, 0, 16'h1234), 1, 16'h1111);
        tbl[5].xv = setf(setf('0, 0, 16'h0034), 1, 16'h7777);
        tbl[5].f = 4'd0;  tbl[5].yh = 16'h1234; tbl[5].e = 16'hEE00;
        tbl[6].wv = setf(setf('0, 1, 16'hFFFF), 2, 16'h0400);
        tbl[6].xv = setf(setf('0, 1, 16'h0001), 2, 16'h0400);
        tbl[6].f = 4'd1;  tbl[6].yh = 16'hFFFF; tbl[6].e = 16'h0001;

        for (int i = 0; i < 7; i++) begin
            wv_cur    = tbl[i].wv;
            feat_cur  = tbl[i].f;
            mem[1]    = tbl[i].xv;
            exp_yh[1] = tbl[i].yh;
            exp_e[1]  = tbl[i].e;
            run_pass(1, 0, 1'b0, $sformatf("vec%0d", i));
        end

        feat_cur = 4'd3;
        run_pass(0, 0, 1'b0, "empty");

        feat_cur = 4'd4;
        wv_cur   = rnd_vec();
        for (int a = 1; a <= 3; a++) begin
            mem[a] = rnd_vec();
            model(wv_cur, mem[a], int'(feat_cur), exp_yh[a], exp_e[a]);
        end
        run_pass(3, 5, 1'b0, "backpressure");

        for (int r = 0; r < 8; r++) begin
            dp       = int'($urandom_range(1, 4));
            feat_cur = 4'($urandom_range(0, 15));
            wv_cur   = rnd_vec();
            for (int a = 1; a <= dp; a++) begin
                mem[a] = rnd_vec();
                model(wv_cur, mem[a], int'(feat_cur), exp_yh[a], exp_e[a]);
            end
            run_pass(dp, int'($urandom_range(0, 3)), 1'(r % 2), $sformatf("rand%0d", r));
        end

        feat_cur = 4'd15;
        wv_cur   = allf(16'h0100);
        mem[1]   = setf(allf(16'h0200), 0, 16'h0000);
        mem[2]   = allf(16'h0300);
        for (int a = 1; a <= 2; a++) model(wv_cur, mem[a], 15, exp_yh[a], exp_e[a]);
        weights = wv_cur; feat = feat_cur; data_points = 12'd2; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("pre_reset busy", 64'(busy), 64'd1);
        RST = 1'b0;
        #1;
        check("midreset addr",    64'(addr),    64'd0);
        check("midreset y_hat",   64'(y_hat),   64'd0);
        check("midreset err",     64'(err),     64'd0);
        check("midreset y_addr",  64'(y_addr),  64'd0);
        check("midreset y_valid", 64'(y_valid), 64'd0);
        check("midreset busy",    64'(busy),    64'd0);
        check("midreset done",    64'(done),    64'd0);
        @(posedge CLK); #1;
        RST = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge CLK); #1;
            check("post_reset no_valid", 64'(y_valid), 64'd0);
        end
        run_pass(2, 1, 1'b0, "after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
